mem_ctr_line: RTL
=================

# mem_ctr_line

Parametrised line-transfer memory controller on bus 2, successor to the fixed 16-bit, 16-byte-line controller. Services READ_LINE/WRITE_LINE commands from the cache over a split (in/out/output-enable) C2/A2/D2 interface, with a configurable bus width, line size and access latency. Adds an optional open-page latency reduction. Fully synthesizable and cycle-counted; no `#` delays.

## Interface
- ADDR_W, 10: line-address width (A2 bits); RAM holds 2^ADDR_W lines.
- DATA_W, 16: D2 width in bits; multiple of 8, divides LINE_BYTES*8.
- LINE_BYTES, 16: bytes per cache line.
- MEM_DELAY, 100: cycles from command edge to first RESPONSE cycle; must exceed BEATS.
- PAGE_HIT_DELAY, 20: latency on open-page hit; must satisfy BEATS < PAGE_HIT_DELAY ≤ MEM_DELAY.
- PAGE_LINES_LOG2, 4: page = line address >> PAGE_LINES_LOG2.
- Derived: BEATS = LINE_BYTES*8/DATA_W.

Ports:
- CLK  in  1  clock; all sampling on posedge.
- RESET  in  1  asynchronous, active-high reset.
- C2_IN  in  2  command from bus: 0 NOP, 1 RESPONSE, 2 READ_LINE, 3 WRITE_LINE.
- C2_OUT  out  2  command driven by controller.
- C2_OE  out  1  controller owns C2.
- A2_IN  in  ADDR_W  line address, valid with command.
- D2_IN  in  DATA_W  write data beats.
- D2_OUT  out  DATA_W  read data beats.
- D2_OE  out  1  controller owns D2.
- BUSY  out  1  command in progress.

## Operation
- States: IDLE, WR_DATA, WAIT, RD_RESP, WR_RESP.
- IDLE: C2_IN sampled every edge. READ_LINE → latch A2_IN, load latency counter, go WAIT. WRITE_LINE → latch A2_IN, write beat 0 from D2_IN on the same edge, go WR_DATA. NOP/RESPONSE/unknown are ignored.
- WR_DATA: write beat k (k=1..BEATS-1) on successive edges, then WAIT.
- WAIT: decrement counter; on expiry go RD_RESP (read) or WR_RESP (write).
- RD_RESP: BEATS cycles, C2_OUT=RESPONSE, D2_OE=1, D2_OUT=beat k. Then IDLE.
- WR_RESP: one cycle C2_OUT=RESPONSE. Then IDLE.
- Beat k carries bytes [k*DATA_W/8 .. (k+1)*DATA_W/8-1] of the line, little-endian: lowest address in D2[7:0].
- Byte address = line_addr*LINE_BYTES + offset. RAM is a byte array (or DATA_W-wide words), never cleared by RESET.
- While BUSY and not in a response cycle: C2_OE=1, C2_OUT=NOP. Commands arriving while BUSY are ignored, never queued.
- Counter width is $clog2(MEM_DELAY+1).

## Timing
- Command edge = T0. Read: RESPONSE and beat k at cycles T0+L+k (k=0..BEATS-1). Write: data beat k sampled at T0+k; RESPONSE at T0+L only. L = MEM_DELAY, or PAGE_HIT_DELAY on an enabled page hit.
- BUSY is high from T0+1 through the last RESPONSE cycle. The next command is accepted on the first edge after that.
- Reset values: C2_OE=0, D2_OE=0, C2_OUT=NOP, D2_OUT=0, BUSY=0, state IDLE, page_valid=0.
- RESET asserted mid-operation: all outputs return to reset values immediately (asynchronously). Beats already written stay in RAM; the remaining beats are not written and no RESPONSE is issued.
- Write to line 2^ADDR_W-1 does not wrap into line 0.

## Configuration
- MEM_CTR_PAGE_HIT_EN defined: the controller keeps open_page and page_valid.
  - A command whose page equals open_page with page_valid=1 uses L=PAGE_HIT_DELAY; otherwise L=MEM_DELAY.
  - Every accepted command sets open_page to its page and page_valid=1.
- Undefined: L=MEM_DELAY always; no page registers; PAGE_HIT_DELAY and PAGE_LINES_LOG2 are unused.

## Test plan
All scenarios use the defaults: BEATS=8.
1. WRITE_LINE to A2=5 at T0 with beats 16'h0100, 16'h0302 … 16'h0F0E → C2_OE=1/NOP from T0+1, single RESPONSE at T0+100, BUSY low at T0+101.
2. READ_LINE to A2=5 → RESPONSE for T0+100..T0+107, D2_OUT = 16'h0100 … 16'h0F0E in order, D2_OE=0 at T0+108.
3. READ_LINE issued during busy (T0+50 of scenario 2) → ignored; a READ_LINE at T0+108 accepted, RESPONSE at T0+208.
4. RESET pulsed at write beat 3 → outputs idle same cycle; following READ of that line returns new beats 0–2 and old beats 3–7; no RESPONSE for the aborted write.
5. With MEM_CTR_PAGE_HIT_EN: READ line 16 (delay 100), then READ line 17 → RESPONSE at T0+20; READ line 32 → 100; after RESET, READ line 33 → 100. Without the macro, all reads → 100.
6. Parameter sweep DATA_W=32, LINE_BYTES=32 → BEATS=8; write/read of line 2^ADDR_W-1 round-trips exactly and line 0 is unchanged.

Source files
------------

// File: rtl/mem_ctr_line.sv
// Line-transfer memory controller on bus 2: READ_LINE / WRITE_LINE over split C2/A2/D2.
// Define MEM_CTR_PAGE_HIT_EN to shorten latency on commands that hit the last open page.
module mem_ctr_line #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 16,
  parameter int LINE_BYTES      = 16,
  parameter int MEM_DELAY       = 100,
  parameter int PAGE_HIT_DELAY  = 20,
  parameter int PAGE_LINES_LOG2 = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        C2_IN,
  output logic [1:0]        C2_OUT,
  output logic              C2_OE,
  input  logic [ADDR_W-1:0] A2_IN,
  input  logic [DATA_W-1:0] D2_IN,
  output logic [DATA_W-1:0] D2_OUT,
  output logic              D2_OE,
  output logic              BUSY
);
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = ADDR_W + BEAT_W;
  localparam int DEPTH  = (2 ** ADDR_W) * BEATS;
  localparam int CNT_W  = $clog2(MEM_DELAY + 1);

  localparam logic [1:0] C_NOP  = 2'd0;
  localparam logic [1:0] C_RESP = 2'd1;
  localparam logic [1:0] C_RD   = 2'd2;
  localparam logic [1:0] C_WR   = 2'd3;

  if ((DATA_W % 8) != 0 || BEATS < 1 || MEM_DELAY <= BEATS ||
      PAGE_HIT_DELAY <= BEATS || PAGE_HIT_DELAY > MEM_DELAY ||
      PAGE_LINES_LOG2 > ADDR_W) begin : g_bad_cfg
    $error("mem_ctr_line: inconsistent parameters");
  end

  typedef enum logic [2:0] {IDLE, WR_DATA, WAIT, RD_RESP, WR_RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   line;
  logic [BEAT_W-1:0]   beat;
  logic [CNT_W-1:0]    cnt;
  logic                rd_op;
  logic [CNT_W-1:0]    lat_load;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_CTR_PAGE_HIT_EN
  logic [ADDR_W-1:0] open_page;
  logic              page_valid;
  logic              page_hit;

  assign page_hit = page_valid && ((A2_IN >> PAGE_LINES_LOG2) == open_page);
  // Loaded two short: counter is checked one edge early so RESPONSE is registered in time.
  assign lat_load = page_hit ? CNT_W'(PAGE_HIT_DELAY - 2) : CNT_W'(MEM_DELAY - 2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      open_page  <= '0;
      page_valid <= 1'b0;
    end else if (state == IDLE && (C2_IN == C_RD || C2_IN == C_WR)) begin
      open_page  <= A2_IN >> PAGE_LINES_LOG2;
      page_valid <= 1'b1;
    end
  end
`else
  assign lat_load = CNT_W'(MEM_DELAY - 2);
`endif

  // Beat 0 of a write lands on the command edge itself, addressed straight from A2.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = IDX_W'(line) * IDX_W'(BEATS) + IDX_W'(beat);
    if (state == IDLE && C2_IN == C_WR) begin
      wr_en  = 1'b1;
      wr_idx = IDX_W'(A2_IN) * IDX_W'(BEATS);
    end else if (state == WR_DATA) begin
      wr_en = 1'b1;
    end
  end

  assign rd_idx = IDX_W'(line) * IDX_W'(BEATS) + IDX_W'(beat) + IDX_W'(state == RD_RESP);

  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) mem[wr_idx] <= D2_IN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      line   <= '0;
      beat   <= '0;
      cnt    <= '0;
      rd_op  <= 1'b0;
      C2_OUT <= C_NOP;
      C2_OE  <= 1'b0;
      D2_OUT <= '0;
      D2_OE  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (C2_IN == C_RD || C2_IN == C_WR) begin
            line   <= A2_IN;
            cnt    <= lat_load;
            rd_op  <= (C2_IN == C_RD);
            C2_OE  <= 1'b1;
            C2_OUT <= C_NOP;
            BUSY   <= 1'b1;
            if (C2_IN == C_RD || BEATS == 1) begin
              beat  <= '0;
              state <= WAIT;
            end else begin
              beat  <= BEAT_W'(1);
              state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          cnt <= cnt - CNT_W'(1);
          if (beat == BEAT_W'(BEATS - 1)) state <= WAIT;
          else beat <= beat + BEAT_W'(1);
        end
        WAIT: begin
          if (cnt == '0) begin
            C2_OUT <= C_RESP;
            if (rd_op) begin
              D2_OE  <= 1'b1;
              D2_OUT <= mem[rd_idx];
              state  <= RD_RESP;
            end else begin
              state <= WR_RESP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (beat == BEAT_W'(BEATS - 1)) begin
            state  <= IDLE;
            C2_OUT <= C_NOP;
            C2_OE  <= 1'b0;
            D2_OE  <= 1'b0;
            D2_OUT <= '0;
            BUSY   <= 1'b0;
          end else begin
            D2_OUT <= mem[rd_idx];
            beat   <= beat + BEAT_W'(1);
          end
        end
        WR_RESP: begin
          state  <= IDLE;
          C2_OUT <= C_NOP;
          C2_OE  <= 1'b0;
          BUSY   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          C2_OUT <= C_NOP;
          C2_OE  <= 1'b0;
          D2_OE  <= 1'b0;
          D2_OUT <= '0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end
endmodule
